// File: rtl/l2_cache_pkg.sv
// Shared widths, MESI/command/bus/snoop encodings and FSM states for the L2 controller.
package l2_cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int TAG_W    = 12;
    localparam int INDEX_W  = 14;
    localparam int OFFSET_W = 6;
    localparam int WAY_W    = 3;

    typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_e;
    typedef enum logic [1:0] {OP_RD = 2'd0, OP_WR = 2'd1, OP_SNP_RD = 2'd2, OP_SNP_INV = 2'd3} cmd_op_e;
    typedef enum logic [1:0] {BUS_READ = 2'd0, BUS_RWIM = 2'd1, BUS_WB = 2'd2, BUS_INV = 2'd3} bus_op_e;
    typedef enum logic [1:0] {SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2} snoop_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_CHECK, ST_WB, ST_FILL, ST_INV, ST_UPDATE, ST_RESP
    } state_e;

    // Line address with the offset bits forced to zero.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/l2_cache_if.sv
// Command/response, tag-array and bus signals of the L2 controller.
interface l2_cache_if;
    import l2_cache_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [ADDR_W-1:0]  cmd_addr;
    logic               resp_valid;
    logic               resp_hit;
    logic [1:0]         snoop_res;

    logic               ta_lookup;
    logic [INDEX_W-1:0] ta_index;
    logic [TAG_W-1:0]   ta_tag;
    logic               ta_hit;
    logic [WAY_W-1:0]   ta_way;
    logic [1:0]         ta_mesi;
    logic [WAY_W-1:0]   ta_vic_way;
    logic [TAG_W-1:0]   ta_vic_tag;
    logic [1:0]         ta_vic_mesi;
    logic               ta_wr_en;
    logic [WAY_W-1:0]   ta_wr_way;
    logic [1:0]         ta_wr_mesi;
    logic               ta_touch;

    logic               bus_req;
    logic [1:0]         bus_op;
    logic [ADDR_W-1:0]  bus_addr;
    logic               bus_done;
    logic [1:0]         bus_snoop;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr,
        output cmd_ready, resp_valid, resp_hit, snoop_res,
        output ta_lookup, ta_index, ta_tag,
        input  ta_hit, ta_way, ta_mesi, ta_vic_way, ta_vic_tag, ta_vic_mesi,
        output ta_wr_en, ta_wr_way, ta_wr_mesi, ta_touch,
        output bus_req, bus_op, bus_addr,
        input  bus_done, bus_snoop
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr,
        input  cmd_ready, resp_valid, resp_hit, snoop_res,
        input  ta_lookup, ta_index, ta_tag,
        output ta_hit, ta_way, ta_mesi, ta_vic_way, ta_vic_tag, ta_vic_mesi,
        input  ta_wr_en, ta_wr_way, ta_wr_mesi, ta_touch,
        input  bus_req, bus_op, bus_addr,
        output bus_done, bus_snoop
    );

endinterface

// File: rtl/l2_bus_seq.sv
// Bus request holder: raises bus_req on start, keeps op/addr stable until bus_done,
// then returns a done pulse and the other caches' snoop result.
module l2_bus_seq
    import l2_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  bus_op_e           op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              bus_done_i,
    input  logic [1:0]        bus_snoop_i,
    output logic              bus_req_o,
    output logic [1:0]        bus_op_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic              done_o,
    output logic [1:0]        snoop_o
);

    logic              req_q, req_d;
    bus_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        snoop_q, snoop_d;

    // A bus_done while no request is outstanding is ignored.
    assign done_o     = req_q & bus_done_i;
    assign bus_req_o  = req_q;
    assign bus_op_o   = op_q;
    assign bus_addr_o = addr_q;
    assign snoop_o    = snoop_q;

    // Completion drops the request; a start latches a new transaction.
    always_comb begin
        req_d   = req_q;
        op_d    = op_q;
        addr_d  = addr_q;
        snoop_d = snoop_q;
        if (done_o) begin
            req_d   = 1'b0;
            snoop_d = bus_snoop_i;
        end else if (start_i) begin
            req_d  = 1'b1;
            op_d   = op_i;
            addr_d = addr_i;
        end
    end

    // Request state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            op_q    <= BUS_READ;
            addr_q  <= '0;
            snoop_q <= '0;
        end else begin
            req_q   <= req_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            snoop_q <= snoop_d;
        end
    end

endmodule

// File: rtl/l2_cache_ctrl.sv
// L2 per-request sequencer: lookup, optional writeback/fill/invalidate, array update, response.
module l2_cache_ctrl
    import l2_cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    l2_cache_if.master  bif
);

    state_e             state_q, state_d;
    cmd_op_e            op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [WAY_W-1:0]   way_q, way_d;
    mesi_e              wr_mesi_q, wr_mesi_d;
    logic               do_wr_q, do_wr_d;
    logic               touch_q, touch_d;
    logic               hit_q, hit_d;
    snoop_e             snp_q, snp_d;

    logic               seq_start;
    bus_op_e            seq_op;
    logic [ADDR_W-1:0]  seq_addr;
    logic               seq_done;
    logic [1:0]         seq_snoop;
    logic               bus_req_w;

    mesi_e              hit_mesi;
    logic               hit;
    mesi_e              fill_mesi;
    logic [OFFSET_W-1:0] unused_offset;

    assign unused_offset = bif.cmd_addr[OFFSET_W-1:0];
    assign hit_mesi      = mesi_e'(bif.ta_mesi);
    // A tag match on an invalid line counts as a miss.
    assign hit           = bif.ta_hit && (hit_mesi != MESI_I);
    assign fill_mesi     = (seq_snoop == SNP_NOHIT) ? MESI_E : MESI_S;

    l2_bus_seq u_bus_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (seq_start),
        .op_i       (seq_op),
        .addr_i     (seq_addr),
        .bus_done_i (bif.bus_done),
        .bus_snoop_i(bif.bus_snoop),
        .bus_req_o  (bus_req_w),
        .bus_op_o   (bif.bus_op),
        .bus_addr_o (bif.bus_addr),
        .done_o     (seq_done),
        .snoop_o    (seq_snoop)
    );

    assign bif.bus_req    = bus_req_w;
    assign bif.cmd_ready  = (state_q == ST_IDLE);
    assign bif.resp_valid = (state_q == ST_RESP);
    assign bif.resp_hit   = (state_q == ST_RESP) && hit_q;
    assign bif.snoop_res  = (state_q == ST_RESP) ? snp_q : SNP_NOHIT;
    assign bif.ta_lookup  = (state_q == ST_LOOKUP);
    assign bif.ta_index   = index_q;
    assign bif.ta_tag     = tag_q;
    assign bif.ta_wr_en   = (state_q == ST_UPDATE) && do_wr_q;
    assign bif.ta_touch   = (state_q == ST_UPDATE) && touch_q;
    assign bif.ta_wr_way  = way_q;
    // A read fill takes E or S from the snoop result returned with the READ.
    assign bif.ta_wr_mesi = (op_q == OP_RD && !hit_q) ? fill_mesi : wr_mesi_q;

    // Next-state logic: decisions are made once in CHECK and held until UPDATE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        index_d   = index_q;
        way_d     = way_q;
        wr_mesi_d = wr_mesi_q;
        do_wr_d   = do_wr_q;
        touch_d   = touch_q;
        hit_d     = hit_q;
        snp_d     = snp_q;
        seq_start = 1'b0;
        seq_op    = BUS_READ;
        seq_addr  = line_addr(tag_q, index_q);
        case (state_q)
            ST_IDLE: begin
                if (bif.cmd_valid) begin
                    op_d    = cmd_op_e'(bif.cmd_op);
                    tag_d   = bif.cmd_addr[ADDR_W-1 -: TAG_W];
                    index_d = bif.cmd_addr[OFFSET_W +: INDEX_W];
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_d = ST_CHECK;
            ST_CHECK: begin
                hit_d     = hit;
                snp_d     = SNP_NOHIT;
                way_d     = bif.ta_way;
                wr_mesi_d = hit_mesi;
                do_wr_d   = 1'b0;
                touch_d   = 1'b0;
                state_d   = ST_UPDATE;
                case (op_q)
                    OP_RD, OP_WR: begin
                        touch_d = 1'b1;
                        if (hit) begin
                            wr_mesi_d = MESI_M;
                            do_wr_d   = (op_q == OP_WR) && (hit_mesi != MESI_M);
                            if (op_q == OP_WR && hit_mesi == MESI_S) begin
                                seq_start = 1'b1;
                                seq_op    = BUS_INV;
                                state_d   = ST_INV;
                            end
                        end else begin
                            way_d     = bif.ta_vic_way;
                            wr_mesi_d = MESI_M;
                            do_wr_d   = 1'b1;
                            seq_start = 1'b1;
                            if (mesi_e'(bif.ta_vic_mesi) == MESI_M) begin
                                seq_op   = BUS_WB;
                                seq_addr = line_addr(bif.ta_vic_tag, index_q);
                                state_d  = ST_WB;
                            end else begin
                                seq_op  = (op_q == OP_WR) ? BUS_RWIM : BUS_READ;
                                state_d = ST_FILL;
                            end
                        end
                    end
                    OP_SNP_RD: begin
                        if (hit) begin
                            wr_mesi_d = MESI_S;
                            do_wr_d   = 1'b1;
                            snp_d     = (hit_mesi == MESI_M) ? SNP_HITM : SNP_HIT;
                            if (hit_mesi == MESI_M) begin
                                seq_start = 1'b1;
                                seq_op    = BUS_WB;
                                state_d   = ST_WB;
                            end
                        end
                    end
                    default: begin
                        wr_mesi_d = MESI_I;
                        do_wr_d   = hit;
                    end
                endcase
            end
            ST_WB: begin
                if (seq_done) state_d = (op_q == OP_SNP_RD) ? ST_UPDATE : ST_FILL;
            end
            ST_FILL: begin
                // Entered from WB with bus_req low: re-request after the one idle cycle.
                if (!bus_req_w) begin
                    seq_start = 1'b1;
                    seq_op    = (op_q == OP_WR) ? BUS_RWIM : BUS_READ;
                end
                if (seq_done) state_d = ST_UPDATE;
            end
            ST_INV: begin
                if (seq_done) state_d = ST_UPDATE;
            end
            ST_UPDATE: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and per-command registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RD;
            tag_q     <= '0;
            index_q   <= '0;
            way_q     <= '0;
            wr_mesi_q <= MESI_I;
            do_wr_q   <= 1'b0;
            touch_q   <= 1'b0;
            hit_q     <= 1'b0;
            snp_q     <= SNP_NOHIT;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            index_q   <= index_d;
            way_q     <= way_d;
            wr_mesi_q <= wr_mesi_d;
            do_wr_q   <= do_wr_d;
            touch_q   <= touch_d;
            hit_q     <= hit_d;
            snp_q     <= snp_d;
        end
    end

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Bench for l2_cache_ctrl: directed commands, a behavioural expectation model, a per-cycle monitor.
module tb_l2_cache_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_cache_if bif();

    l2_cache_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bif  (bif)
    );

    typedef struct {
        int          nbus;
        logic [1:0]  bop0, bop1;
        logic [31:0] ba0, ba1;
        bit          wr;
        logic [2:0]  wway;
        logic [1:0]  wmesi;
        bit          touch;
        bit          hit;
        logic [1:0]  snp;
        int          lat;
        logic [31:0] addr;
    } exp_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t cur;
    bit   hold_bus = 1'b0;
    int   resp_cnt = 0;

    // monitor state
    bit          active = 1'b0;
    int          cyc, bidx, nwr, ntouch, low_cnt, bcnt;
    logic        prev_req;
    logic [1:0]  cap_op, cap_op0, last_wmesi, last_snp;
    logic [31:0] cap_addr, cap_addr0;
    int          last_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outcome of one command, straight from the MESI/bus rules.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] addr, input bit thit,
                                   input logic [2:0] way, input logic [1:0] mesi,
                                   input logic [2:0] vway, input logic [11:0] vtag,
                                   input logic [1:0] vmesi, input logic [1:0] snoop);
        exp_t e;
        logic [31:0] line, vline;
        logic [1:0]  ops[$];
        logic [31:0] adrs[$];
        bit          h;
        line  = {addr[31:6], 6'd0};
        vline = {vtag, addr[19:6], 6'd0};
        h     = thit && (mesi != 2'd0);
        e = '{nbus: 0, bop0: 0, bop1: 0, ba0: 0, ba1: 0, wr: 0, wway: way, wmesi: 0,
              touch: 0, hit: h, snp: 0, lat: 0, addr: addr};
        case (op)
            2'd0, 2'd1: begin
                e.touch = 1;
                if (h) begin
                    if (op == 2'd1) begin
                        e.wr = (mesi != 2'd3);
                        e.wmesi = 2'd3;
                        if (mesi == 2'd1) begin ops.push_back(2'd3); adrs.push_back(line); end
                    end
                end else begin
                    e.wr = 1; e.wway = vway;
                    e.wmesi = (op == 2'd1) ? 2'd3 : ((snoop == 2'd0) ? 2'd2 : 2'd1);
                    if (vmesi == 2'd3) begin ops.push_back(2'd2); adrs.push_back(vline); end
                    ops.push_back((op == 2'd1) ? 2'd1 : 2'd0); adrs.push_back(line);
                end
            end
            2'd2: begin
                if (h) begin
                    e.wr = 1; e.wmesi = 2'd1;
                    e.snp = (mesi == 2'd3) ? 2'd2 : 2'd1;
                    if (mesi == 2'd3) begin ops.push_back(2'd2); adrs.push_back(line); end
                end
            end
            default: begin
                if (h) begin e.wr = 1; e.wmesi = 2'd0; end
            end
        endcase
        e.nbus = ops.size();
        if (e.nbus > 0) begin e.bop0 = ops[0]; e.ba0 = adrs[0]; end
        if (e.nbus > 1) begin e.bop1 = ops[1]; e.ba1 = adrs[1]; end
        // bus responder answers after 2 request cycles; WB->FILL has one idle cycle
        e.lat = 4 + 2 * e.nbus + ((e.nbus == 2) ? 1 : 0);
        return e;
    endfunction

    // One negedge of checking against the current expectation.
    task automatic mon_step();
        if (!rst_n) begin
            active = 0; prev_req = 0;
            return;
        end
        if (!active) begin
            chk("idle_bus_req", bif.bus_req, 0);
            chk("idle_wr_en", bif.ta_wr_en, 0);
            if (bif.cmd_valid && bif.cmd_ready) begin
                active = 1; cyc = 0; bidx = 0; nwr = 0; ntouch = 0; low_cnt = 0; prev_req = 0;
            end
            return;
        end
        cyc++;
        chk("busy_ready", bif.cmd_ready, 0);
        chk("ta_lookup", bif.ta_lookup, (cyc == 1) ? 1 : 0);
        chk("ta_index", bif.ta_index, cur.addr[19:6]);
        chk("ta_tag", bif.ta_tag, cur.addr[31:20]);
        if (bif.bus_req && !prev_req) begin
            if (bidx >= cur.nbus) begin
                chk("bus_extra", bidx, cur.nbus - 1);
            end else begin
                chk("bus_op", bif.bus_op, (bidx == 0) ? cur.bop0 : cur.bop1);
                chk("bus_addr", bif.bus_addr, (bidx == 0) ? cur.ba0 : cur.ba1);
                if (bidx == 1) chk("bus_gap", low_cnt, 1);
                if (bidx == 0) begin cap_op0 = bif.bus_op; cap_addr0 = bif.bus_addr; end
            end
            cap_op = bif.bus_op; cap_addr = bif.bus_addr;
            bidx++;
        end else if (bif.bus_req) begin
            chk("bus_op_stable", bif.bus_op, cap_op);
            chk("bus_addr_stable", bif.bus_addr, cap_addr);
        end
        if (!bif.bus_req) low_cnt = prev_req ? 1 : low_cnt + 1;
        if (bif.ta_wr_en) begin
            nwr++;
            chk("wr_way", bif.ta_wr_way, cur.wway);
            chk("wr_mesi", bif.ta_wr_mesi, cur.wmesi);
            last_wmesi = bif.ta_wr_mesi;
        end
        if (bif.ta_touch) begin
            ntouch++;
            chk("touch_way", bif.ta_wr_way, cur.wway);
        end
        if (bif.resp_valid) begin
            chk("resp_hit", bif.resp_hit, cur.hit);
            chk("snoop_res", bif.snoop_res, cur.snp);
            chk("n_writes", nwr, cur.wr);
            chk("n_touch", ntouch, cur.touch);
            chk("n_bus", bidx, cur.nbus);
            chk("latency", cyc, cur.lat);
            last_lat = cyc; last_snp = bif.snoop_res;
            active = 0;
            resp_cnt++;
        end
        prev_req = bif.bus_req;
    endtask

    // Issue one command (called at posedge+1) and wait for its response.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input bit thit,
                           input logic [2:0] way, input logic [1:0] mesi, input logic [2:0] vway,
                           input logic [11:0] vtag, input logic [1:0] vmesi, input logic [1:0] snoop);
        int start;
        start = resp_cnt;
        cur = model(op, addr, thit, way, mesi, vway, vtag, vmesi, snoop);
        bif.ta_hit = thit; bif.ta_way = way; bif.ta_mesi = mesi;
        bif.ta_vic_way = vway; bif.ta_vic_tag = vtag; bif.ta_vic_mesi = vmesi;
        bif.bus_snoop = snoop;
        bif.cmd_op = op; bif.cmd_addr = addr; bif.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
        for (int i = 0; i < 40 && resp_cnt == start; i++) begin
            @(posedge clk); #1;
        end
        chk("resp_seen", resp_cnt - start, 1);
    endtask

    initial begin
        bif.cmd_valid = 0; bif.cmd_op = 0; bif.cmd_addr = 0;
        bif.ta_hit = 0; bif.ta_way = 0; bif.ta_mesi = 0;
        bif.ta_vic_way = 0; bif.ta_vic_tag = 0; bif.ta_vic_mesi = 0;
        bif.bus_done = 0; bif.bus_snoop = 0;
        prev_req = 0; bcnt = 0;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                @(negedge clk);
                if (rst_n && bif.bus_req && !hold_bus) begin
                    bcnt++;
                    bif.bus_done = (bcnt == 2);
                end else begin
                    bcnt = 0;
                    bif.bus_done = 1'b0;
                end
            end
        join_none

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", bif.cmd_ready, 1);
        chk("rst_bus_req", bif.bus_req, 0);
        chk("rst_resp_valid", bif.resp_valid, 0);
        chk("rst_snoop_res", bif.snoop_res, 0);
        chk("rst_ta_lookup", bif.ta_lookup, 0);
        chk("rst_ta_index", bif.ta_index, 0);
        chk("rst_ta_tag", bif.ta_tag, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        //      op     addr          hit way  mesi vway vtag    vmesi snoop
        run_cmd(2'd0, 32'h1110_0000, 0, 3'd0, 2'd0, 3'd3, 12'h000, 2'd0, 2'd0);
        chk("t1_lit_mesi", last_wmesi, 2'd2);
        chk("t1_lit_busop", cap_op0, 2'd0);
        run_cmd(2'd0, 32'h1110_0000, 1, 3'd2, 2'd2, 3'd3, 12'h000, 2'd0, 2'd0);
        chk("t2_lit_latency", last_lat, 4);
        run_cmd(2'd1, 32'h1110_0000, 1, 3'd2, 2'd1, 3'd3, 12'h000, 2'd0, 2'd0);
        chk("t3_lit_mesi", last_wmesi, 2'd3);
        run_cmd(2'd0, 32'h3330_0000, 0, 3'd0, 2'd0, 3'd5, 12'h222, 2'd3, 2'd1);
        chk("t4_lit_wb_addr", cap_addr0, 32'h2220_0000);
        chk("t4_lit_latency", last_lat, 9);
        run_cmd(2'd2, 32'h4440_0040, 1, 3'd1, 2'd3, 3'd0, 12'h000, 2'd0, 2'd0);
        chk("t5_lit_hitm", last_snp, 2'd2);
        run_cmd(2'd3, 32'h4440_0080, 0, 3'd0, 2'd0, 3'd4, 12'h777, 2'd3, 2'd0);
        run_cmd(2'd3, 32'h4440_0080, 1, 3'd6, 2'd2, 3'd4, 12'h777, 2'd3, 2'd0);
        run_cmd(2'd1, 32'h5551_2340, 1, 3'd4, 2'd2, 3'd0, 12'h000, 2'd0, 2'd0);
        run_cmd(2'd1, 32'h5551_2340, 1, 3'd4, 2'd3, 3'd0, 12'h000, 2'd0, 2'd0);
        run_cmd(2'd1, 32'h6660_00c0, 0, 3'd0, 2'd0, 3'd7, 12'h0ab, 2'd3, 2'd2);
        run_cmd(2'd1, 32'h6660_0100, 0, 3'd0, 2'd0, 3'd1, 12'h0cd, 2'd2, 2'd0);
        run_cmd(2'd2, 32'h7770_0000, 1, 3'd3, 2'd1, 3'd0, 12'h000, 2'd0, 2'd0);
        run_cmd(2'd2, 32'h7770_0000, 0, 3'd3, 2'd0, 3'd0, 12'h000, 2'd0, 2'd0);
        run_cmd(2'd0, 32'h8880_0400, 0, 3'd0, 2'd0, 3'd6, 12'h111, 2'd1, 2'd2);

        // reset while a FILL is waiting on the bus
        hold_bus = 1'b1;
        cur = model(2'd0, 32'h9990_0000, 0, 3'd0, 2'd0, 3'd2, 12'h000, 2'd0, 2'd0);
        bif.ta_hit = 0; bif.ta_vic_way = 3'd2; bif.ta_vic_mesi = 2'd0;
        bif.cmd_op = 2'd0; bif.cmd_addr = 32'h9990_0000; bif.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !bif.bus_req; i++) begin
            @(posedge clk); #1;
        end
        chk("t6_req_before_rst", bif.bus_req, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_bus_req", bif.bus_req, 0);
        chk("t6_cmd_ready", bif.cmd_ready, 1);
        chk("t6_wr_en", bif.ta_wr_en, 0);
        chk("t6_resp_valid", bif.resp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold_bus = 1'b0;
        @(posedge clk); #1;
        run_cmd(2'd0, 32'h1110_0000, 1, 3'd2, 2'd2, 3'd3, 12'h000, 2'd0, 2'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
